// File: rtl/mips_mem_pkg.sv
// Shared encodings and default widths for the MIPS unified-memory arbiter.
package mips_mem_pkg;

  localparam int MIPS_AW = 10;
  localparam int MIPS_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: IF and DM share one memory, one transaction in flight,
// DM has priority and IF is forced through after FAIR_LIMIT consecutive losses.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = MIPS_AW,
  parameter int DW         = MIPS_DW,
  parameter int MEM_LAT    = 1,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  // Handshake: a requester holds req and its payload until its gnt pulse; the
  // matching rvalid pulses exactly once, MEM_LAT+1 cycles after that gnt.

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(FAIR_LIMIT);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          own_we_q, own_we_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
  logic [DW-1:0] if_rdata_d, dm_rdata_d;
  logic          m_en_d, m_we_d, busy_d;
  logic [AW-1:0] m_addr_d;
  logic [DW-1:0] m_wdata_d;
  logic          arb;
  logic          if_win;

  assign if_win = if_req && (!dm_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    own_we_d    = own_we_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    m_en_d      = 1'b0;
    m_we_d      = 1'b0;
    m_addr_d    = m_addr;
    m_wdata_d   = m_wdata;
    arb         = 1'b0;

    unique case (state_q)
      IDLE:  arb = 1'b1;
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_INIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = own_we_q ? '0 : m_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = m_rdata;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RESP:  arb = 1'b1;
      default: state_d = IDLE;
    endcase

    // Arbitration point: shared by IDLE and RESP so RESP can chain straight into ISSUE.
    if (arb) begin
      state_d = IDLE;
      if (!if_req) starve_d = '0;
      if (!halt && (if_req || dm_req)) begin
        state_d = ISSUE;
        m_en_d  = 1'b1;
        if (if_win) begin
          owner_d   = OWN_IF;
          own_we_d  = 1'b0;
          if_gnt_d  = 1'b1;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          starve_d  = '0;
        end else begin
          owner_d   = OWN_DM;
          own_we_d  = dm_we;
          dm_gnt_d  = 1'b1;
          m_we_d    = dm_we;
          m_addr_d  = dm_addr;
          m_wdata_d = dm_wdata;
          if (if_req && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      own_we_q  <= 1'b0;
      lat_q     <= '0;
      starve_q  <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      own_we_q  <= own_we_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      m_en      <= m_en_d;
      m_we      <= m_we_d;
      m_addr    <= m_addr_d;
      m_wdata   <= m_wdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance at MEM_LAT=1 with a synchronous
// RAM model, a second at MEM_LAT=3 with a pipelined address-pattern memory.
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MEM_LAT=1, FAIR_LIMIT=4
  logic        rst, halt, if_req, dm_req, dm_we;
  logic [9:0]  if_addr, dm_addr, m_addr;
  logic [31:0] dm_wdata, if_rdata, dm_rdata, m_wdata, m_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, m_en, m_we, busy;

  // Instance B: MEM_LAT=3
  logic        rst_b, halt_b, if_req_b, dm_req_b, dm_we_b;
  logic [9:0]  if_addr_b, dm_addr_b, m_addr_b;
  logic [31:0] dm_wdata_b, if_rdata_b, dm_rdata_b, m_wdata_b, m_rdata_b;
  logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b, m_en_b, m_we_b, busy_b;

  int checks = 0;
  int errors = 0;

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .FAIR_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst_b), .halt(halt_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .dm_rdata(dm_rdata_b),
    .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b),
    .busy(busy_b)
  );

  // Synchronous RAM: read data appears the cycle after m_en, writes commit on that edge.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
      mem[5]  <= 32'h2842_000A;
      mem[20] <= 32'h0000_0055;
      m_rdata <= 32'h0;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
    end
  end

  // Three-stage memory for instance B: data = address XOR a fixed pattern.
  logic [31:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1     <= m_en_b ? ({22'h0, m_addr_b} ^ 32'hA5A5_0000) : 32'h0;
    pipe2     <= pipe1;
    m_rdata_b <= pipe2;
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      nx();
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] exp_seq;
    int g, dbl, rv_cnt;

    rst = 1'b1; halt = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    rst_b = 1'b1; halt_b = 1'b0; if_req_b = 1'b0; if_addr_b = '0;
    dm_req_b = 1'b0; dm_we_b = 1'b0; dm_addr_b = '0; dm_wdata_b = '0;
    repeat (3) nx();
    rst = 1'b0; rst_b = 1'b0;
    nx();

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_outs_zero", {31'b0, |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                   m_en, m_we, m_addr, m_wdata}}, 32'd0);
    chk("rst_b_outs_zero", {31'b0, |{if_gnt_b, if_rvalid_b, if_rdata_b, dm_gnt_b, dm_rvalid_b,
                                     dm_rdata_b, m_en_b, m_we_b, m_addr_b, m_wdata_b, busy_b}}, 32'd0);

    // Single IF read of addr 5
    if_req = 1'b1; if_addr = 10'd5;
    nx();
    chk("if1_gnt", {31'b0, if_gnt}, 32'd1);
    chk("if1_dm_gnt", {31'b0, dm_gnt}, 32'd0);
    chk("if1_m_en", {31'b0, m_en}, 32'd1);
    chk("if1_m_we", {31'b0, m_we}, 32'd0);
    chk("if1_m_addr", {22'b0, m_addr}, 32'd5);
    chk("if1_busy", {31'b0, busy}, 32'd1);
    if_req = 1'b0;
    nx();
    chk("if1_wait_gnt", {31'b0, if_gnt}, 32'd0);
    chk("if1_wait_m_en", {31'b0, m_en}, 32'd0);
    chk("if1_wait_rvalid", {31'b0, if_rvalid}, 32'd0);
    nx();
    chk("if1_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("if1_rdata", if_rdata, 32'h2842_000A);
    chk("if1_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
    nx();
    chk("if1_rvalid_pulse", {31'b0, if_rvalid}, 32'd0);
    chk("if1_idle", {31'b0, busy}, 32'd0);

    // Simultaneous IF addr 0 and DM read addr 20
    if_req = 1'b1; if_addr = 10'd0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    nx();
    chk("sim_dm_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("sim_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("sim_m_addr", {22'b0, m_addr}, 32'd20);
    dm_req = 1'b0;
    nx();
    nx();
    chk("sim_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("sim_dm_rdata", dm_rdata, 32'h0000_0055);
    chk("sim_if_rvalid_quiet", {31'b0, if_rvalid}, 32'd0);
    nx();
    chk("sim_if_gnt_b2b", {31'b0, if_gnt}, 32'd1);
    chk("sim_if_m_addr", {22'b0, m_addr}, 32'd0);
    if_req = 1'b0;
    nx();
    nx();
    chk("sim_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("sim_if_rdata", if_rdata, 32'h1000_0000);
    wait_idle("sim_idle");

    // Fairness with both ports held high
    exp_seq = 10'b10_0001_0000;
    if_req = 1'b1; if_addr = 10'd3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    g = 0; dbl = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      nx();
      if (if_gnt && dm_gnt) dbl++;
      if (if_rvalid && dm_rvalid) dbl++;
      if (if_gnt || dm_gnt) begin
        chk($sformatf("fair_gnt%0d_is_if", g), {31'b0, if_gnt}, {31'b0, exp_seq[g]});
        g++;
      end
    end
    chk("fair_gnt_count", g, 32'd10);
    chk("fair_onehot", dbl, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle("fair_idle");

    // DM write then IF read-back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd25; dm_wdata = 32'hDEAD_BEEF;
    nx();
    chk("wr_gnt", {31'b0, dm_gnt}, 32'd1);
    chk("wr_m_we", {31'b0, m_we}, 32'd1);
    chk("wr_m_addr", {22'b0, m_addr}, 32'd25);
    chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    dm_req = 1'b0; dm_we = 1'b0;
    nx();
    chk("wr_m_we_pulse", {31'b0, m_we}, 32'd0);
    nx();
    chk("wr_ack", {31'b0, dm_rvalid}, 32'd1);
    chk("wr_ack_rdata", dm_rdata, 32'd0);
    nx();
    if_req = 1'b1; if_addr = 10'd25;
    nx();
    chk("rb_gnt", {31'b0, if_gnt}, 32'd1);
    if_req = 1'b0;
    nx();
    nx();
    chk("rb_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("rb_rdata", if_rdata, 32'hDEAD_BEEF);
    wait_idle("rb_idle");

    // halt during WAIT of an IF read while both ports request
    if_req = 1'b1; if_addr = 10'd5;
    nx();
    chk("halt_if_gnt", {31'b0, if_gnt}, 32'd1);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20;
    nx();
    halt = 1'b1;
    nx();
    chk("halt_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("halt_rdata", if_rdata, 32'h2842_000A);
    for (int c = 0; c < 4; c++) begin
      nx();
      chk($sformatf("halt_no_gnt%0d", c), {31'b0, if_gnt | dm_gnt}, 32'd0);
      chk($sformatf("halt_parked%0d", c), {31'b0, busy}, 32'd0);
    end
    halt = 1'b0;
    nx();
    chk("halt_resume_dm", {31'b0, dm_gnt}, 32'd1);
    chk("halt_resume_if", {31'b0, if_gnt}, 32'd0);
    dm_req = 1'b0;
    nx();
    nx();
    chk("halt_dm_rdata", dm_rdata, 32'h0000_0055);
    nx();
    chk("halt_if_after", {31'b0, if_gnt}, 32'd1);
    if_req = 1'b0;
    wait_idle("halt_idle");

    // Instance B: full read at MEM_LAT=3
    if_req_b = 1'b1; if_addr_b = 10'd7;
    nx();
    chk("b_gnt", {31'b0, if_gnt_b}, 32'd1);
    if_req_b = 1'b0;
    nx(); nx(); nx();
    chk("b_no_early_rvalid", {31'b0, if_rvalid_b}, 32'd0);
    nx();
    chk("b_rvalid", {31'b0, if_rvalid_b}, 32'd1);
    chk("b_rdata", if_rdata_b, 32'hA5A5_0007);
    nx();
    chk("b_idle", {31'b0, busy_b}, 32'd0);

    // Instance B: reset during WAIT aborts the read
    if_req_b = 1'b1; if_addr_b = 10'd9;
    nx();
    chk("b2_gnt", {31'b0, if_gnt_b}, 32'd1);
    if_req_b = 1'b0;
    nx();
    rst_b = 1'b1;
    nx();
    rst_b = 1'b0;
    chk("b2_rst_busy", {31'b0, busy_b}, 32'd0);
    chk("b2_rst_outs_zero", {31'b0, |{if_gnt_b, if_rvalid_b, if_rdata_b, dm_gnt_b, dm_rvalid_b,
                                      dm_rdata_b, m_en_b, m_we_b, m_addr_b, m_wdata_b}}, 32'd0);
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      nx();
      if (if_rvalid_b || busy_b) rv_cnt++;
    end
    chk("b2_no_rvalid", rv_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
